serial_adder: RTL and testbench

Bit-serial, parametrised-width adder/subtractor. Processes one bit per clock, LSB first, through a single full-adder cell built from two `halfadder` instances. This makes it the multi-bit, sequential successor of the existing 1-bit half adder. It sits in the beginner arithmetic set as the first block with a start/done handshake and an FSM, and trades latency for a one-bit datapath.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/halfadder.sv | 21 ++
 rtl/serial_adder_full_adder.sv | 42 ++++
 rtl/serial_adder.sv | 148 ++++++++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and limits for the bit-serial adder/subtractor.
//                - state_t : FSM state encoding (IDLE, RUN, DONE)
//                - c_WIDTH_MIN / c_WIDTH_MAX : legal operand width range
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_WIDTH_MIN = 2;
    localparam int c_WIDTH_MAX = 64;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/halfadder.sv
`default_nettype none
// ============================================================================
//  Module      : halfadder
//  Description : 1-bit half adder.
//  Ports       : a, b  - input bits
//                s     - sum bit (a ^ b)
//                c     - carry bit (a & b)
//  Revision    : 1.0 - initial release
// ============================================================================
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : halfadder
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : 1-bit full adder built from two half adders and an OR gate.
//                This cell is the only arithmetic in the serial adder.
//  Ports       : a, b  - operand bits
//                ci    - carry in
//                s     - sum bit
//                co    - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    halfadder u_ha0 (
        .a (a),
        .b (b),
        .s (w_s0),
        .c (w_c0)
    );

    halfadder u_ha1 (
        .a (w_s0),
        .b (ci),
        .s (s),
        .c (w_c1)
    );

    // The two half-adder carries can never both be 1, so OR is sufficient.
    assign co = w_c0 | w_c1;

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder/subtractor. One bit per clock,
//                LSB first, through a single full-adder cell. Start/done
//                handshake, WIDTH clocks of latency.
//  Ports       : clk      - clock, rising edge
//                rst_n    - synchronous active-low reset
//                start    - request operation (sampled in IDLE only)
//                sub      - 0: a+b, 1: a-b (sampled with start)
//                a, b     - operands (captured on accepted start)
//                busy     - operation in progress
//                done     - one-cycle pulse with a new result
//                sum      - result, held until next completion
//                carry    - carry out of MSB (sub: 1 = no borrow)
//                overflow - two's-complement signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    import serial_adder_pkg::*;

    localparam int                 c_CNT_W       = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST    = c_CNT_W'(WIDTH - 1);
    // Edge on which the cell produces the carry that feeds the MSB.
    localparam logic [c_CNT_W-1:0] c_CNT_MSB_CIN = c_CNT_W'(WIDTH - 2);

    if (WIDTH < c_WIDTH_MIN || WIDTH > c_WIDTH_MAX) begin : g_width_illegal
        $error("serial_adder: WIDTH must be between 2 and 64");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_c;
    logic               r_msb_cin;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_overflow;

    logic               w_fa_s;
    logic               w_fa_co;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;

    full_adder u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_c),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at
    // position 0.
    assign w_res_next = {w_fa_s, r_res[WIDTH-1:1]};
    assign w_last     = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:                w_state_next = IDLE;
            default:             w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_c        <= 1'b0;
            r_msb_cin  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Status flags follow the next state so they are valid in the
            // same cycle as the state they describe.
            r_busy  <= (w_state_next == RUN);
            r_done  <= (w_state_next == DONE);

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        // Subtraction is a + ~b + 1; the +1 rides in on the
                        // initial carry.
                        r_b   <= sub ? ~b : b;
                        r_c   <= sub;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_fa_co;
                    if (r_cnt == c_CNT_MSB_CIN) begin
                        r_msb_cin <= w_fa_co;
                    end
                    if (w_last) begin
                        r_sum      <= w_res_next;
                        r_carry    <= w_fa_co;
                        r_overflow <= r_msb_cin ^ w_fa_co;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign carry    = r_carry;
    assign overflow = r_overflow;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH = 8). Results are
//                compared with an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;

    int           n_checks;
    int           n_pass;
    logic [W-1:0] last_sum;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: true integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                  output logic [W-1:0] rs, output logic rc, output logic ro);
        longint ux, uy, sx, sy, ur, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= (64'sd1 <<< (W-1))) ? ux - (64'sd1 <<< W) : ux;
        sy = (uy >= (64'sd1 <<< (W-1))) ? uy - (64'sd1 <<< W) : uy;
        if (!s) begin
            ur = ux + uy;
            sr = sx + sy;
            rc = (ur >= (64'sd1 <<< W));
        end else begin
            ur = ux - uy + (64'sd1 <<< W);
            sr = sx - sy;
            rc = (ux >= uy);
        end
        rs = W'(ur);
        ro = (sr > ((64'sd1 <<< (W-1)) - 1)) || (sr < -(64'sd1 <<< (W-1)));
    endfunction

    // One operation from IDLE; stray start pulses at edges 3 and W must be
    // ignored, and operands are scrambled right after acceptance.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                         input string tag);
        logic [W-1:0] es;
        logic         ec, eo;
        int           n;
        model(ta, tb_, ts, es, ec, eo);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; sub = ts;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        n = 0;
        while (n < W + 4) begin
            @(posedge clk); n++; #1;
            if (done) break;
            if (n == 4) check({tag, "_sum_hold"}, 64'(sum), 64'(last_sum));
            if (n == W - 1) check({tag, "_busy_mid"}, 64'(busy), 64'd1);
            if (n == 2 || n == W - 1) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_done_edge"}, 64'(n), 64'(W));
        check({tag, "_sum"},       64'(sum), 64'(es));
        check({tag, "_carry"},     64'(carry), 64'(ec));
        check({tag, "_ovf"},       64'(overflow), 64'(eo));
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
        last_sum = es;
        @(posedge clk); #1;
        check({tag, "_done_fall"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] op_a [0:63];
        logic [W-1:0] op_b [0:63];
        logic         op_s [0:63];
        logic [W-1:0] es;
        logic         ec, eo;
        int           next_done, ndone, nbad;

        n_checks = 0;
        n_pass   = 0;
        last_sum = '0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum",  64'(sum), 64'd0);
        check("rst_flags", {59'd0, busy, done, carry, overflow, 1'b0}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed boundary cases
        do_op(8'h3C, 8'h0F, 1'b0, "add_3c_0f");
        do_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        do_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
        do_op(8'h05, 8'h07, 1'b1, "sub_05_07");
        do_op(8'h80, 8'h01, 1'b1, "sub_80_01");

        // Reset asserted at edge 4 of an operation
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h66; sub = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_sum",   64'(sum), 64'd0);
        check("midrst_flags", {60'd0, busy, done, carry, overflow}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        last_sum = '0;
        nbad = 0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (done) nbad++;
        end
        check("midrst_no_done", 64'(nbad), 64'd0);
        do_op(8'h10, 8'h20, 1'b0, "after_rst");

        // start held high, operands changing every cycle
        next_done = W;
        ndone     = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 3 * (W + 2); k++) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            op_a[k] = a; op_b[k] = b; op_s[k] = sub;
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check("held_done_edge", 64'(k), 64'(next_done));
                model(op_a[next_done - W], op_b[next_done - W], op_s[next_done - W], es, ec, eo);
                check("held_sum",   64'(sum), 64'(es));
                check("held_carry", 64'(carry), 64'(ec));
                check("held_ovf",   64'(overflow), 64'(eo));
                last_sum = es;
                next_done += W + 2;
            end else if (k == 5 || k == 15) begin
                check("held_sum_stable", 64'(sum), 64'(last_sum));
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("held_done_count", 64'(ndone), 64'd3);

        // Random operations against the reference model
        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
